// File: rtl/b16_muldiv.sv
// Multi-cycle unsigned multiply-accumulate (a_lo*b + a_hi) and 2L/L restoring divide.
// One shift-add/subtract step per clock; start/busy/done handshake, results held until next done.
module b16_muldiv #(
  parameter int L  = 16,
  parameter int CW = $clog2(L+1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         op,
  input  logic [L-1:0] a_hi,
  input  logic [L-1:0] a_lo,
  input  logic [L-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [L-1:0] res_hi,
  output logic [L-1:0] res_lo,
  output logic         ovf,
  output logic         zero
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [L-1:0]  hi, lo, bq;
  logic          opq;
  logic [CW-1:0] cnt;
  logic          accept, div_ovf, last;
  logic [L:0]    s, t;
  logic          q;
  logic [L-1:0]  hi_nxt, lo_nxt;

  always_comb begin
    accept  = start && (state != RUN);
    div_ovf = op && (a_hi >= b);
    last    = (cnt == CW'(1));
  end

  // One iteration of the working pair; the divide keeps hi < bq, so t-b fits in L bits.
  always_comb begin
    s      = {1'b0, hi} + (lo[0] ? {1'b0, bq} : '0);
    t      = {hi, lo[L-1]};
    q      = (t >= {1'b0, bq});
    hi_nxt = s[L:1];
    lo_nxt = {s[0], lo[L-1:1]};
    if (opq) begin
      hi_nxt = q ? (t[L-1:0] - bq) : t[L-1:0];
      lo_nxt = {lo[L-2:0], q};
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = (state == RUN);
    done      = (state == DONE);
    case (state)
      IDLE, DONE: begin
        if (accept)             state_nxt = div_ovf ? DONE : RUN;
        else if (state == DONE) state_nxt = IDLE;
      end
      RUN:     if (last) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      hi     <= '0;
      lo     <= '0;
      bq     <= '0;
      opq    <= 1'b0;
      cnt    <= '0;
      res_hi <= '0;
      res_lo <= '0;
      ovf    <= 1'b0;
      zero   <= 1'b1;
    end else begin
      state <= state_nxt;
      if (accept) begin
        opq <= op;
        bq  <= b;
        hi  <= a_hi;
        lo  <= a_lo;
        cnt <= CW'(L);
        // Quotient cannot fit: report operands untouched and skip the iteration.
        if (div_ovf) begin
          res_hi <= a_hi;
          res_lo <= a_lo;
          ovf    <= 1'b1;
          zero   <= (a_hi == '0) && (a_lo == '0);
        end
      end else if (state == RUN) begin
        hi  <= hi_nxt;
        lo  <= lo_nxt;
        cnt <= cnt - CW'(1);
        if (last) begin
          res_hi <= hi_nxt;
          res_lo <= lo_nxt;
          ovf    <= 1'b0;
          zero   <= ({hi_nxt, lo_nxt} == '0);
        end
      end
    end
  end

endmodule
